// File: rtl/uart_handler_pkg.sv
// Shared definitions for the UART wishbone master handler: state encodings,
// ASCII frame constants and field sizes.
package uart_handler_pkg;

  typedef enum logic [7:0] {
    StIdle        = 8'h00,
    StSendId      = 8'h01,
    StSendCount   = 8'h02,
    StSendStatus  = 8'h03,
    StSendAddress = 8'h04,
    StSendData    = 8'h05,
    StWaitData    = 8'h06,
    StSendEol     = 8'h07
  } state_e;

  localparam logic [7:0] CHAR_S          = 8'h53;
  localparam logic [7:0] CHAR_0          = 8'h30;
  localparam logic [7:0] CHAR_HEX_OFFSET = 8'h37;
  localparam logic [7:0] CHAR_NL         = 8'h0A;
  localparam logic [7:0] CHAR_L          = 8'h4C;

  localparam int unsigned COUNT_NIBBLES = 7;
  localparam int unsigned WORD_NIBBLES  = 8;

  // True when the nibble counter points at the last nibble of an n-nibble field.
  function automatic logic is_last_nibble(input logic [3:0] cnt, input int unsigned n);
    return cnt == 4'(n - 1);
  endfunction

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Combinational nibble to uppercase ASCII hex digit converter.
module hex_nibble_to_ascii
  import uart_handler_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_ascii
);

  // Digits map onto '0'..'9'; 10..15 map onto 'A'..'F' (0x37 + n).
  always_comb begin
    if (i_nibble < 4'd10) begin
      o_ascii = CHAR_0 + {4'h0, i_nibble};
    end else begin
      o_ascii = CHAR_HEX_OFFSET + {4'h0, i_nibble};
    end
  end

endmodule

// File: rtl/uart_output_handler.sv
// Response serializer: turns a status/address/data response into an ASCII-hex
// byte stream for the UART transmitter, pulling extra data words on demand.
module uart_output_handler
  import uart_handler_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [31:0] i_status,
  input  logic [31:0] i_address,
  input  logic [31:0] i_data,
  input  logic [27:0] i_data_count,
  input  logic        i_uart_ready,
  output logic [7:0]  o_byte_out,
  output logic        o_write_byte,
  output logic        o_busy,
  output logic        o_data_request,
  output logic        o_finished
);

  state_e      r_state;
  state_e      w_state_next;
  logic [3:0]  r_nib_cnt;
  logic [27:0] r_count_sh;
  logic [27:0] r_remaining;
  logic [31:0] r_status_sh;
  logic [31:0] r_address_sh;
  logic [31:0] r_data_sh;
  logic        r_write_byte;
  logic        w_sending;
  logic        w_strobe;
  logic        w_last;
  logic [3:0]  w_nibble;
  logic [7:0]  w_hex;

  hex_nibble_to_ascii u_hex (
    .i_nibble(w_nibble),
    .o_ascii (w_hex)
  );

  assign w_sending = r_state inside {StSendId, StSendCount, StSendStatus, StSendAddress,
                                     StSendData, StSendEol};
  // A byte goes out at most every other cycle so the transmitter can drop ready;
  // the reset cycle never emits.
  assign w_strobe  = w_sending && i_uart_ready && !r_write_byte && !i_rst;

  assign o_write_byte   = w_strobe;
  assign o_busy         = r_state != StIdle;
  assign o_data_request = r_state == StWaitData;
  assign o_finished     = w_strobe && (r_state == StSendEol);

  // Select the MSB nibble of the active field and flag its final nibble.
  always_comb begin
    w_nibble = 4'h0;
    w_last   = 1'b0;
    case (r_state)
      StSendId:      w_last = 1'b1;
      StSendCount: begin
        w_nibble = r_count_sh[27:24];
        w_last   = is_last_nibble(r_nib_cnt, COUNT_NIBBLES);
      end
      StSendStatus: begin
        w_nibble = r_status_sh[31:28];
        w_last   = is_last_nibble(r_nib_cnt, WORD_NIBBLES);
      end
      StSendAddress: begin
        w_nibble = r_address_sh[31:28];
        w_last   = is_last_nibble(r_nib_cnt, WORD_NIBBLES);
      end
      StSendData: begin
        w_nibble = r_data_sh[31:28];
        w_last   = is_last_nibble(r_nib_cnt, WORD_NIBBLES);
      end
      StSendEol:     w_last = 1'b1;
      default:       ;
    endcase
  end

  // Byte presented to the transmitter; held steady until strobed.
  always_comb begin
    o_byte_out = 8'h00;
    case (r_state)
      StSendId:                                          o_byte_out = CHAR_S;
      StSendCount, StSendStatus, StSendAddress, StSendData: o_byte_out = w_hex;
      StSendEol:                                         o_byte_out = CHAR_NL;
      default:                                           ;
    endcase
  end

  // Next-state logic: fields advance on the strobe of their last nibble.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:     if (i_en) w_state_next = StSendId;
      StWaitData: if (i_en) w_state_next = StSendData;
      default:    ;
    endcase
    if (w_strobe && w_last) begin
      case (r_state)
        StSendId:      w_state_next = StSendCount;
        StSendCount:   w_state_next = StSendStatus;
        StSendStatus:  w_state_next = StSendAddress;
        StSendAddress: w_state_next = StSendData;
        StSendData:    w_state_next = (r_remaining != '0) ? StWaitData : StSendEol;
        StSendEol:     w_state_next = StIdle;
        default:       ;
      endcase
    end
    if (!(r_state inside {StIdle, StSendId, StSendCount, StSendStatus, StSendAddress,
                          StSendData, StWaitData, StSendEol})) begin
      w_state_next = StIdle;
    end
  end

  // State register, strobe history and per-field nibble counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_write_byte <= 1'b0;
      r_nib_cnt    <= 4'h0;
    end else begin
      r_state      <= w_state_next;
      r_write_byte <= w_strobe;
      if (w_state_next != r_state) begin
        r_nib_cnt <= 4'h0;
      end else if (w_strobe) begin
        r_nib_cnt <= r_nib_cnt + 4'h1;
      end
    end
  end

  // Field latches and left shifts; remaining count saturates at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count_sh   <= '0;
      r_remaining  <= '0;
      r_status_sh  <= '0;
      r_address_sh <= '0;
      r_data_sh    <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_en) begin
            r_count_sh   <= i_data_count;
            r_remaining  <= i_data_count;
            r_status_sh  <= i_status;
            r_address_sh <= i_address;
            r_data_sh    <= i_data;
          end
        end
        StWaitData:    if (i_en) r_data_sh <= i_data;
        StSendCount:   if (w_strobe) r_count_sh <= {r_count_sh[23:0], 4'h0};
        StSendStatus:  if (w_strobe) r_status_sh <= {r_status_sh[27:0], 4'h0};
        StSendAddress: if (w_strobe) r_address_sh <= {r_address_sh[27:0], 4'h0};
        StSendData: begin
          if (w_strobe) begin
            r_data_sh <= {r_data_sh[27:0], 4'h0};
            if (w_last && (r_remaining != '0)) r_remaining <= r_remaining - 28'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
